// File: rtl/wakeup_ready_array_pkg.sv
// ============================================================================
// wakeup_ready_array_pkg : shared core types for issue-queue wakeup logic
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef SIZE_ISSUEQ
`define SIZE_ISSUEQ 16
`endif
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 2
`endif
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 2
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 6
`endif

package wakeup_ready_array_pkg;

    localparam int c_IQ_ID_WIDTH = $clog2(`SIZE_ISSUEQ);
    localparam int c_PHYS_WIDTH  = `SIZE_PHYSICAL_LOG;

    typedef struct packed {
        logic [c_PHYS_WIDTH-1:0] reg_id;
        logic                    valid;
    } phys_reg;

    typedef struct packed {
        logic [c_PHYS_WIDTH-1:0] phySrc1;
        logic [c_PHYS_WIDTH-1:0] phySrc2;
        logic                    src1Ready;
        logic                    src2Ready;
    } iqPkt;

    typedef struct packed {
        logic [c_IQ_ID_WIDTH-1:0] id;
    } iqEntryPkt;

endpackage

`default_nettype wire

// File: rtl/wakeup_ready_array_cam_entry.sv
// ============================================================================
// wakeup_cam_entry : one IQ entry's source-tag comparators and ready state
// Revision: 1.0
// ============================================================================
`default_nettype none

module wakeup_cam_entry
    import wakeup_ready_array_pkg::*;
#(
    parameter int ISSUE_WIDTH       = `ISSUE_WIDTH,
    parameter int SIZE_PHYSICAL_LOG = `SIZE_PHYSICAL_LOG
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    i_flush,
    input  logic    i_wrEn,
    input  iqPkt    i_wrPkt,
    input  phys_reg i_rsrTag [ISSUE_WIDTH],
    input  logic    i_granted,
    input  logic    i_freed,
    output logic    o_valid,
    output logic    o_req
);

    logic                         r_valid;
    logic                         r_scheduled;
    logic                         r_src1Ready;
    logic                         r_src2Ready;
    logic [SIZE_PHYSICAL_LOG-1:0] r_phySrc1;
    logic [SIZE_PHYSICAL_LOG-1:0] r_phySrc2;

    logic w_wake1, w_wake2, w_byp1, w_byp2;

    // Stored sources wake from the tag bus; incoming sources bypass it on dispatch.
    always_comb begin
        w_wake1 = 1'b0;
        w_wake2 = 1'b0;
        w_byp1  = 1'b0;
        w_byp2  = 1'b0;
        for (int t = 0; t < ISSUE_WIDTH; t++) begin
            if (i_rsrTag[t].valid) begin
                if (i_rsrTag[t].reg_id == r_phySrc1)       w_wake1 = 1'b1;
                if (i_rsrTag[t].reg_id == r_phySrc2)       w_wake2 = 1'b1;
                if (i_rsrTag[t].reg_id == i_wrPkt.phySrc1) w_byp1  = 1'b1;
                if (i_rsrTag[t].reg_id == i_wrPkt.phySrc2) w_byp2  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_scheduled <= 1'b0;
            r_src1Ready <= 1'b0;
            r_src2Ready <= 1'b0;
            r_phySrc1   <= '0;
            r_phySrc2   <= '0;
        end else if (i_flush) begin
            r_valid     <= 1'b0;
            r_scheduled <= 1'b0;
            r_src1Ready <= 1'b0;
            r_src2Ready <= 1'b0;
            r_phySrc1   <= '0;
            r_phySrc2   <= '0;
        end else if (i_wrEn) begin
            r_valid     <= 1'b1;
            r_scheduled <= 1'b0;
            r_src1Ready <= i_wrPkt.src1Ready | w_byp1;
            r_src2Ready <= i_wrPkt.src2Ready | w_byp2;
            r_phySrc1   <= i_wrPkt.phySrc1;
            r_phySrc2   <= i_wrPkt.phySrc2;
        end else if (i_freed) begin
            r_valid     <= 1'b0;
            r_scheduled <= 1'b0;
        end else if (r_valid) begin
            if (i_granted) r_scheduled <= 1'b1;
            if (w_wake1)   r_src1Ready <= 1'b1;
            if (w_wake2)   r_src2Ready <= 1'b1;
        end
    end

    assign o_valid = r_valid;
    assign o_req   = r_valid & ~r_scheduled & r_src1Ready & r_src2Ready;

endmodule

`default_nettype wire

// File: rtl/wakeup_ready_array.sv
// ============================================================================
// wakeup_ready_array : issue-queue wakeup/ready array with occupancy counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module wakeup_ready_array
    import wakeup_ready_array_pkg::*;
#(
    parameter int SIZE_ISSUEQ       = `SIZE_ISSUEQ,
    parameter int DISPATCH_WIDTH    = `DISPATCH_WIDTH,
    parameter int ISSUE_WIDTH       = `ISSUE_WIDTH,
    parameter int SIZE_PHYSICAL_LOG = `SIZE_PHYSICAL_LOG
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         dispatchReady_i,
    input  logic [DISPATCH_WIDTH-1:0]    dispatchLaneActive_i,
    input  iqPkt                         iqPacket_i [DISPATCH_WIDTH],
    input  iqEntryPkt                    freeEntry_i [DISPATCH_WIDTH],
    input  phys_reg                      rsrTag_i [ISSUE_WIDTH],
    input  logic [SIZE_ISSUEQ-1:0]       grantedVect_i,
    input  logic [SIZE_ISSUEQ-1:0]       freedVect_i,
    output logic [SIZE_ISSUEQ-1:0]       reqVect_o,
    output logic [SIZE_ISSUEQ-1:0]       validVect_o,
    output logic [$clog2(SIZE_ISSUEQ):0] cntInstIQ_o
);

    localparam int c_CNT_WIDTH = $clog2(SIZE_ISSUEQ) + 1;

    logic [SIZE_ISSUEQ-1:0] w_wrEn;
    iqPkt                   w_wrPkt [SIZE_ISSUEQ];
    logic [SIZE_ISSUEQ-1:0] w_valid;
    logic [SIZE_ISSUEQ-1:0] w_req;
    logic [c_CNT_WIDTH-1:0] w_dispCnt;
    logic [c_CNT_WIDTH-1:0] w_freeCnt;
    logic [c_CNT_WIDTH-1:0] r_cnt;

    // Steer each active lane's packet to its target entry.
    always_comb begin
        w_wrEn = '0;
        for (int i = 0; i < SIZE_ISSUEQ; i++) w_wrPkt[i] = '0;
        if (dispatchReady_i) begin
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                if (dispatchLaneActive_i[k]) begin
                    w_wrEn[freeEntry_i[k].id]  = 1'b1;
                    w_wrPkt[freeEntry_i[k].id] = iqPacket_i[k];
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < SIZE_ISSUEQ; i++) begin : g_entry
            wakeup_cam_entry #(
                .ISSUE_WIDTH       (ISSUE_WIDTH),
                .SIZE_PHYSICAL_LOG (SIZE_PHYSICAL_LOG)
            ) u_entry (
                .clk       (clk),
                .reset     (reset),
                .i_flush   (flush_i),
                .i_wrEn    (w_wrEn[i]),
                .i_wrPkt   (w_wrPkt[i]),
                .i_rsrTag  (rsrTag_i),
                .i_granted (grantedVect_i[i]),
                .i_freed   (freedVect_i[i]),
                .o_valid   (w_valid[i]),
                .o_req     (w_req[i])
            );
        end
    endgenerate

    // A free of a valid entry that is re-dispatched the same cycle nets to zero.
    always_comb begin
        w_dispCnt = '0;
        w_freeCnt = '0;
        for (int i = 0; i < SIZE_ISSUEQ; i++) begin
            w_dispCnt = w_dispCnt + c_CNT_WIDTH'(w_wrEn[i]);
            w_freeCnt = w_freeCnt + c_CNT_WIDTH'(freedVect_i[i] & w_valid[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + w_dispCnt - w_freeCnt;
        end
    end

    assign reqVect_o   = w_req;
    assign validVect_o = w_valid;
    assign cntInstIQ_o = r_cnt;

    a_noLiveOverwrite: assert property (@(posedge clk) disable iff (reset)
        ((w_wrEn & w_valid & ~freedVect_i) == '0));

    a_cntBound: assert property (@(posedge clk) disable iff (reset)
        (r_cnt <= c_CNT_WIDTH'(SIZE_ISSUEQ)));

endmodule

`default_nettype wire

// File: tb/tb_wakeup_ready_array.sv
// ============================================================================
// tb_wakeup_ready_array : directed-vector bench for wakeup_ready_array
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wakeup_ready_array;
    import wakeup_ready_array_pkg::*;

    localparam int c_N  = 16;
    localparam int c_DW = 2;
    localparam int c_IW = 2;

    logic            clk;
    logic            reset;
    logic            flush;
    logic            dispatchReady;
    logic [c_DW-1:0] laneActive;
    iqPkt            iqPacket [c_DW];
    iqEntryPkt       freeEntry [c_DW];
    phys_reg         rsrTag [c_IW];
    logic [c_N-1:0]  grantedVect;
    logic [c_N-1:0]  freedVect;
    logic [c_N-1:0]  reqVect;
    logic [c_N-1:0]  validVect;
    logic [4:0]      cntInstIQ;

    int numChecks = 0;
    int numPassed = 0;
    logic [c_N-1:0] expValid;
    int lane;

    wakeup_ready_array dut (
        .clk                  (clk),
        .reset                (reset),
        .flush_i              (flush),
        .dispatchReady_i      (dispatchReady),
        .dispatchLaneActive_i (laneActive),
        .iqPacket_i           (iqPacket),
        .freeEntry_i          (freeEntry),
        .rsrTag_i             (rsrTag),
        .grantedVect_i        (grantedVect),
        .freedVect_i          (freedVect),
        .reqVect_o            (reqVect),
        .validVect_o          (validVect),
        .cntInstIQ_o          (cntInstIQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs === exp) numPassed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn;
        flush         = 1'b0;
        dispatchReady = 1'b0;
        laneActive    = '0;
        grantedVect   = '0;
        freedVect     = '0;
        for (int k = 0; k < c_DW; k++) begin
            iqPacket[k]  = '0;
            freeEntry[k] = '0;
        end
        for (int t = 0; t < c_IW; t++) rsrTag[t] = '0;
    endtask

    task automatic setLane(input int k, input int e, input int p1, input logic r1,
                           input int p2, input logic r2);
        dispatchReady        = 1'b1;
        laneActive[k]        = 1'b1;
        freeEntry[k].id      = c_IQ_ID_WIDTH'(e);
        iqPacket[k].phySrc1  = c_PHYS_WIDTH'(p1);
        iqPacket[k].phySrc2  = c_PHYS_WIDTH'(p2);
        iqPacket[k].src1Ready = r1;
        iqPacket[k].src2Ready = r2;
    endtask

    task automatic setTag(input int t, input int id, input logic v);
        rsrTag[t].reg_id = c_PHYS_WIDTH'(id);
        rsrTag[t].valid  = v;
    endtask

    initial begin
        reset = 1'b1;
        clearIn();
        tick();
        tick();
        checkVal("rst_req",   32'(reqVect),   0);
        checkVal("rst_valid", 32'(validVect), 0);
        checkVal("rst_cnt",   32'(cntInstIQ), 0);
        reset = 1'b0;
        tick();

        // Delayed wakeup on entry 5 via tag lane 1
        setLane(0, 5, 12, 1'b0, 3, 1'b1);
        tick();
        clearIn();
        checkVal("wk_valid5", 32'(validVect[5]), 1);
        checkVal("wk_req5_a", 32'(reqVect[5]),   0);
        checkVal("wk_cnt1",   32'(cntInstIQ),    1);
        tick();
        checkVal("wk_req5_b", 32'(reqVect[5]),   0);
        setTag(1, 12, 1'b1);
        #2;
        checkVal("wk_req5_c", 32'(reqVect[5]),   0);
        tick();
        clearIn();
        checkVal("wk_req5_d", 32'(reqVect[5]),   1);

        // Same-cycle bypass into entry 3
        setLane(0, 3, 7, 1'b0, 9, 1'b1);
        setTag(0, 7, 1'b1);
        tick();
        clearIn();
        checkVal("byp_req3", 32'(reqVect[3]), 1);
        checkVal("byp_cnt",  32'(cntInstIQ),  2);

        // Invalid tags never wake
        setLane(0, 6, 0, 1'b0, 0, 1'b0);
        tick();
        clearIn();
        setTag(0, 0, 1'b0);
        setTag(1, 0, 1'b0);
        tick();
        clearIn();
        checkVal("inv_req6", 32'(reqVect[6]), 0);
        checkVal("inv_cnt",  32'(cntInstIQ),  3);

        // Grant then free of entry 2
        setLane(0, 2, 20, 1'b1, 21, 1'b1);
        tick();
        clearIn();
        checkVal("gr_req2_a",  32'(reqVect[2]), 1);
        checkVal("gr_cnt4",    32'(cntInstIQ),  4);
        grantedVect[2] = 1'b1;
        tick();
        clearIn();
        checkVal("gr_req2_b",  32'(reqVect[2]),   0);
        checkVal("gr_valid2",  32'(validVect[2]), 1);
        freedVect[2] = 1'b1;
        tick();
        clearIn();
        checkVal("fr_valid2",  32'(validVect[2]), 0);
        checkVal("fr_cnt3",    32'(cntInstIQ),    3);

        // Free and re-dispatch of entry 4 in the same cycle
        setLane(0, 4, 1, 1'b1, 2, 1'b1);
        tick();
        clearIn();
        grantedVect[4] = 1'b1;
        tick();
        clearIn();
        checkVal("fd_req4_a", 32'(reqVect[4]), 0);
        checkVal("fd_cnt4_a", 32'(cntInstIQ),  4);
        freedVect[4] = 1'b1;
        setLane(0, 4, 1, 1'b1, 2, 1'b1);
        tick();
        clearIn();
        checkVal("fd_valid4", 32'(validVect[4]), 1);
        checkVal("fd_req4_b", 32'(reqVect[4]),   1);
        checkVal("fd_cnt4_b", 32'(cntInstIQ),    4);

        // Two-lane dispatch with two frees
        setLane(0, 8, 30, 1'b1, 31, 1'b1);
        setLane(1, 9, 32, 1'b0, 33, 1'b1);
        freedVect[5] = 1'b1;
        freedVect[3] = 1'b1;
        tick();
        clearIn();
        checkVal("dl_valid", 32'(validVect), 32'h0350);
        checkVal("dl_cnt",   32'(cntInstIQ), 4);
        checkVal("dl_req",   32'(reqVect),   32'h0110);

        // Fill every free entry, then flush
        expValid = 16'h0350;
        lane = 0;
        for (int e = 0; e < c_N; e++) begin
            if (!expValid[e]) begin
                setLane(lane, e, e, 1'b1, e + 1, 1'b1);
                expValid[e] = 1'b1;
                lane++;
                if (lane == c_DW) begin
                    tick();
                    clearIn();
                    lane = 0;
                end
            end
        end
        if (lane != 0) begin
            tick();
            clearIn();
        end
        checkVal("fill_cnt",   32'(cntInstIQ), 16);
        checkVal("fill_valid", 32'(validVect), 32'hFFFF);
        flush       = 1'b1;
        grantedVect = '1;
        setTag(0, 32, 1'b1);
        tick();
        clearIn();
        checkVal("fl_cnt",   32'(cntInstIQ), 0);
        checkVal("fl_req",   32'(reqVect),   0);
        checkVal("fl_valid", 32'(validVect), 0);

        // Asynchronous reset in the middle of dispatch
        setLane(0, 1, 2, 1'b1, 3, 1'b1);
        setLane(1, 2, 4, 1'b1, 5, 1'b1);
        tick();
        clearIn();
        checkVal("ar_cnt_pre", 32'(cntInstIQ), 2);
        setLane(0, 10, 6, 1'b1, 7, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        checkVal("ar_valid", 32'(validVect), 0);
        checkVal("ar_req",   32'(reqVect),   0);
        checkVal("ar_cnt",   32'(cntInstIQ), 0);
        tick();
        clearIn();
        #2;
        reset = 1'b0;
        tick();
        checkVal("post_req",   32'(reqVect),   0);
        checkVal("post_valid", 32'(validVect), 0);
        checkVal("post_cnt",   32'(cntInstIQ), 0);

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wakeup_ready_array.md
WAKEUP_READY_ARRAY -- requirements
Module: wakeup_ready_array

Interface
REQ-001 SHALL have parameters: SIZE_ISSUEQ, default `SIZE_ISSUEQ, number of IQ entries; DISPATCH_WIDTH, default `DISPATCH_WIDTH, dispatch lanes; ISSUE_WIDTH, default `ISSUE_WIDTH, wakeup tag broadcasters; SIZE_PHYSICAL_LOG, default `SIZE_PHYSICAL_LOG, physical register id width.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- flush_i  in  1  synchronous pipeline flush.
- dispatchReady_i  in  1  dispatch group valid this cycle.
- dispatchLaneActive_i  in  DISPATCH_WIDTH  per-lane write enable.
- iqPacket_i  in  iqPkt[DISPATCH_WIDTH]  phySrc1/2, src1Ready/src2Ready of the dispatched instructions.
- freeEntry_i  in  iqEntryPkt[DISPATCH_WIDTH]  target entry id per lane.
- rsrTag_i  in  phys_reg[ISSUE_WIDTH]  wakeup tags, one per issue lane.
- grantedVect_i  in  SIZE_ISSUEQ  entries selected this cycle, OR of all lanes.
- freedVect_i  in  SIZE_ISSUEQ  entries released by payload stage.
- reqVect_o  out  SIZE_ISSUEQ  ready-to-select request vector.
- validVect_o  out  SIZE_ISSUEQ  allocated entries.
- cntInstIQ_o  out  log2(SIZE_ISSUEQ)+1  occupancy.

Function
REQ-003 SHALL keep per-entry registers: valid, scheduled, src1Ready, src2Ready, phySrc1, phySrc2.
REQ-004 SHALL drive reqVect_o[i] = valid & ~scheduled & src1Ready & src2Ready, combinationally from the registered state only.
REQ-005 SHALL, per cycle, compare every valid entry's phySrc1/phySrc2 against all ISSUE_WIDTH rsrTag_i.reg_id with rsrTag_i.valid=1, and set the matching ready bit at the next edge. The broadcast cycle is N and reqVect_o rises in cycle N+1.
REQ-006 SHALL ignore tags whose valid=0 regardless of reg_id.
REQ-007 SHALL, on dispatchReady_i & dispatchLaneActive_i[k], write entry freeEntry_i[k].id:
- valid=1, scheduled=0.
- phySrc from the packet.
- srcNReady = packet srcNReady OR a same-cycle rsrTag_i match (bypass).
REQ-008 SHALL set scheduled on grantedVect_i[i] and never clear it except by free, dispatch or flush.
REQ-009 SHALL clear valid and scheduled on freedVect_i[i].
REQ-010 SHALL resolve simultaneous events on one entry: dispatch > free > grant > wakeup. A dispatch overwriting a freed entry in the same cycle leaves the entry valid.
REQ-011 SHALL treat dispatch to an entry that is already valid and not freed that cycle as illegal. A simulation assertion fires; the write still occurs.
REQ-012 SHALL update cntInstIQ_o each edge by +(dispatched lanes) −popcount(freedVect_i & valid), counting a same-entry dispatch+free as net +0. It never exceeds SIZE_ISSUEQ (assertion).
REQ-013 SHALL ignore grantedVect_i bits for invalid entries.

Reset
REQ-014 SHALL on reset (asynchronous) clear all valid, scheduled and ready bits, the phySrc fields and the counter. reqVect_o=0, validVect_o=0, cntInstIQ_o=0.
REQ-015 SHALL on flush_i perform the same clear at the next edge, overriding same-cycle dispatch, grant, free and wakeup.
REQ-016 SHALL require reset deasserted mid-operation to leave the array empty with no spurious request in the first post-reset cycle.

Structure
REQ-017 SHALL take phys_reg, iqPkt and iqEntryPkt from the shared core package; no new typedefs in this module.
REQ-018 SHALL factor the per-entry comparator and ready state into one sub-module, wakeup_cam_entry, instantiated SIZE_ISSUEQ times.
REQ-019 SHALL keep the popcount/occupancy logic in the top module.

Verification
REQ-020 Dispatch entry 5 with phySrc1=12 not ready and src2 ready; rsrTag_i[1]={12,valid} two cycles later -> reqVect_o[5]=0 until one cycle after the tag, then 1.
REQ-021 Dispatch entry 3 with phySrc1=7 not ready while rsrTag_i[0]={7,valid} in the same cycle -> reqVect_o[3]=1 in the next cycle (bypass).
REQ-022 Entry 2 ready; grantedVect_i[2]=1 -> reqVect_o[2]=0 next cycle with validVect_o[2]=1. Then freedVect_i[2]=1 -> validVect_o[2]=0 and cntInstIQ_o decrements by 1.
REQ-023 Same cycle: freedVect_i[4]=1 and dispatch to entry 4 -> validVect_o[4]=1, scheduled=0, cntInstIQ_o unchanged.
REQ-024 Fill all SIZE_ISSUEQ entries, then flush_i -> cntInstIQ_o=0 and reqVect_o=0 next cycle. Assert reset asynchronously mid-dispatch -> outputs 0 immediately.
REQ-025 rsrTag_i={0,invalid} with entries waiting on phySrc=0 -> no ready bit set.
